// File: rtl/param_serial_tx_pkg.sv
// param_serial_tx_pkg
//   Definitions shared by the serial transmitter and its frame counter:
//   - FSM state encoding (IDLE / SHIFT / DONE)
//   - a width helper for counters and indices that stays at least 1 bit wide
package param_serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } tx_state_e;

  // Index width needed to address n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/param_serial_tx_frame_counter.sv
// tx_frame_counter
//   Bit counter (0..BPW-1) nested inside a word counter (0..N_WORDS-1).
//   The bit counter wraps to 0 and advances the word counter. The word counter
//   wraps to 0 after the last word, so it is back at 0 once a frame completes.
// Ports
//   clk, rst         clock, synchronous active-high reset
//   clr              synchronous clear of both counters
//   en               advance by one bit position
//   bit_cnt          current bit position within the word
//   word_cnt         current word index
//   bit_tc, word_tc  terminal count flags (bit_cnt==BPW-1, word_cnt==N_WORDS-1)
module tx_frame_counter
  import param_serial_tx_pkg::*;
#(
  parameter int BPW     = 4,
  parameter int N_WORDS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  output logic [idx_w(BPW)-1:0]       bit_cnt,
  output logic [idx_w(N_WORDS)-1:0]   word_cnt,
  output logic                        bit_tc,
  output logic                        word_tc
);

  localparam int BW = idx_w(BPW);
  localparam int IW = idx_w(N_WORDS);

  // Terminal-count decode.
  always_comb begin
    bit_tc  = (bit_cnt == BW'(BPW - 1));
    word_tc = (word_cnt == IW'(N_WORDS - 1));
  end

  // Nested bit/word counter registers.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else if (en) begin
      if (bit_tc) begin
        bit_cnt  <= '0;
        word_cnt <= word_tc ? '0 : (word_cnt + IW'(1));
      end else begin
        bit_cnt  <= bit_cnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/param_serial_tx.sv
// param_serial_tx
//   Parallel-to-serial transmitter. Holds N_WORDS words of WORD_W bits, each
//   loadable while idle. On start, it sends the whole frame on one serial line:
//   word 0 first, one bit per cycle, and an optional even-parity bit after each
//   word. The words are read through a bit/word index mux and are never shifted,
//   so another start resends the same contents.
// Ports
//   clk, rst   clock, synchronous active-high reset
//   din        packed words, word i = din[i*WORD_W +: WORD_W]
//   ld         per-word load enables, honoured only in IDLE
//   start      frame request, sampled only in IDLE
//   tx_data    serial bit (0 when tx_valid=0)
//   tx_valid   a frame bit is on tx_data this cycle
//   tx_last    last bit of the frame
//   word_idx   index of the word being sent (0 when not shifting)
//   busy       high in SHIFT and DONE
//   done       one-cycle pulse in the cycle after the last bit
module param_serial_tx
  import param_serial_tx_pkg::*;
#(
  parameter int WORD_W    = 4,
  parameter int N_WORDS   = 4,
  parameter int LSB_FIRST = 1,
  parameter int PARITY_EN = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_WORDS*WORD_W-1:0]   din,
  input  logic [N_WORDS-1:0]          ld,
  input  logic                        start,
  output logic                        tx_data,
  output logic                        tx_valid,
  output logic                        tx_last,
  output logic [idx_w(N_WORDS)-1:0]   word_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int BPW = WORD_W + ((PARITY_EN != 0) ? 1 : 0);
  localparam int BW  = idx_w(BPW);
  localparam int IW  = idx_w(N_WORDS);
  localparam int PW  = idx_w(WORD_W);

  tx_state_e         state;
  tx_state_e         state_nxt;
  logic [WORD_W-1:0] words [N_WORDS];
  logic              cnt_clr;
  logic              cnt_en;
  logic [BW-1:0]     bit_cnt;
  logic [IW-1:0]     word_cnt;
  logic              bit_tc;
  logic              word_tc;
  logic [WORD_W-1:0] cur_word;
  logic [PW-1:0]     bit_pos;
  logic              bit_sel;

  // Even parity: the bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [WORD_W-1:0] w);
    return ^w;
  endfunction

  tx_frame_counter #(
    .BPW     (BPW),
    .N_WORDS (N_WORDS)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .bit_cnt  (bit_cnt),
    .word_cnt (word_cnt),
    .bit_tc   (bit_tc),
    .word_tc  (word_tc)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and counter control. The counter is held clear in IDLE,
  // so the first SHIFT cycle starts at bit 0 of word 0.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (start) begin
          state_nxt = ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        cnt_en = 1'b1;
        if (bit_tc && word_tc) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Word registers: loads are honoured only while idle, so a frame sees stable data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_WORDS; i++) begin
        words[i] <= '0;
      end
    end else if (state == ST_IDLE) begin
      for (int i = 0; i < N_WORDS; i++) begin
        if (ld[i]) begin
          words[i] <= din[i*WORD_W +: WORD_W];
        end
      end
    end
  end

  // Bit select: parity occupies the slot after the data bits; otherwise a
  // data bit is chosen by position, in either order.
  always_comb begin
    cur_word = words[word_cnt];
    if (LSB_FIRST != 0) begin
      bit_pos = PW'(bit_cnt);
    end else begin
      bit_pos = PW'(WORD_W - 1) - PW'(bit_cnt);
    end
    if ((PARITY_EN != 0) && (bit_cnt == BW'(WORD_W))) begin
      bit_sel = even_parity(cur_word);
    end else begin
      bit_sel = cur_word[bit_pos];
    end
  end

  // Output decode from the registered state and counters.
  always_comb begin
    tx_valid = (state == ST_SHIFT);
    tx_data  = tx_valid & bit_sel;
    tx_last  = tx_valid & bit_tc & word_tc;
    word_idx = tx_valid ? word_cnt : '0;
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE);
  end

endmodule
